// File: rtl/mod_exp.sv
// mod_exp: left-to-right square-and-multiply modular exponentiation controller.
// Each product comes from one shared combinational multiplier. The product is
// handed to an external shift-subtract divider, and the divider's remainder is
// taken back as the reduced value.
//
// Handshakes:
//   start/busy/finish - start is sampled only while idle. busy rises on the
//     accepting edge and falls on the edge that raises finish. finish is a
//     one-cycle pulse, and result/err are valid in that cycle.
//   div_start/div_finish - div_start is a registered one-cycle pulse.
//     div_dividend and div_divisor stay stable from that pulse until the
//     divider's div_finish pulse. div_remainder is consumed only in the cycle
//     div_finish is high and only in a WAIT state; a div_finish seen anywhere
//     else is ignored.
module mod_exp #(
    parameter int WIDTH      = 8,
    parameter int EXP_W      = 4,
    parameter int CONST_TIME = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH/2-1:0]   base,
    input  logic [EXP_W-1:0]     exponent,
    input  logic [WIDTH/2-1:0]   modulus,
    output logic [WIDTH/2-1:0]   result,
    output logic                 busy,
    output logic                 finish,
    output logic                 err,
    output logic                 div_start,
    output logic [WIDTH-1:0]     div_dividend,
    output logic [WIDTH-1:0]     div_divisor,
    input  logic [WIDTH-1:0]     div_remainder,
    input  logic                 div_finish,
    output logic [2:0]           dbg_state
);

    localparam int HALF  = WIDTH / 2;
    localparam int BIT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_B   = 3'd1,
        S_WAIT_SQ  = 3'd2,
        S_WAIT_MUL = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [EXP_W-1:0]   r_exp;
    logic [HALF-1:0]    r_b_red;
    logic [HALF-1:0]    r_r;
    logic [BIT_W-1:0]   r_bit_idx;
    logic [HALF-1:0]    r_result;
    logic               r_busy;
    logic               r_finish;
    logic               r_err;
    logic               r_div_start;
    logic [WIDTH-1:0]   r_div_dividend;
    logic [WIDTH-1:0]   r_div_divisor;

    logic [HALF-1:0]    w_r_next;
    logic [HALF-1:0]    w_b_red_next;
    logic [BIT_W-1:0]   w_bit_next;
    logic               w_load;
    logic               w_issue;
    logic               w_advance;
    logic [HALF-1:0]    w_mul_a;
    logic [HALF-1:0]    w_mul_b;
    logic [WIDTH-1:0]   w_product;
    logic [WIDTH-1:0]   w_dividend_next;
    logic [HALF-1:0]    w_rem_h;
    logic               w_exp_bit;
    logic               w_unused_rem;

    // Every reduced value is below the modulus, so only the low half of the
    // remainder carries information.
    assign w_rem_h      = div_remainder[HALF-1:0];
    assign w_unused_rem = ^div_remainder[WIDTH-1:HALF];
    assign w_exp_bit    = r_exp[r_bit_idx];

    assign result       = r_result;
    assign busy         = r_busy;
    assign finish       = r_finish;
    assign err          = r_err;
    assign div_start    = r_div_start;
    assign div_dividend = r_div_dividend;
    assign div_divisor  = r_div_divisor;
    assign dbg_state    = r_state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, next working values, and multiplier operand selection.
    always_comb begin
        w_next_state = r_state;
        w_r_next     = r_r;
        w_b_red_next = r_b_red;
        w_bit_next   = r_bit_idx;
        w_load       = 1'b0;
        w_issue      = 1'b0;
        w_advance    = 1'b0;
        w_mul_a      = '0;
        w_mul_b      = '0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_r_next   = HALF'(1);
                    w_bit_next = BIT_W'(EXP_W - 1);
                    if (modulus == '0) begin
                        w_next_state = S_DONE;
                    end else begin
                        // Pre-reduce the base so later multiplies see base mod m.
                        w_issue      = 1'b1;
                        w_next_state = S_WAIT_B;
                    end
                end
            end
            S_WAIT_B: begin
                if (div_finish) begin
                    w_b_red_next = w_rem_h;
                    w_issue      = 1'b1;
                    w_mul_a      = r_r;
                    w_mul_b      = r_r;
                    w_next_state = S_WAIT_SQ;
                end
            end
            S_WAIT_SQ: begin
                if (div_finish) begin
                    w_r_next = w_rem_h;
                    if (w_exp_bit || (CONST_TIME != 0)) begin
                        w_issue      = 1'b1;
                        w_mul_a      = w_rem_h;
                        w_mul_b      = r_b_red;
                        w_next_state = S_WAIT_MUL;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            S_WAIT_MUL: begin
                if (div_finish) begin
                    // On a 0 bit this was a dummy multiply; its result is dropped.
                    if (w_exp_bit) begin
                        w_r_next = w_rem_h;
                    end
                    w_advance = 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (w_advance) begin
            if (r_bit_idx == '0) begin
                w_next_state = S_DONE;
            end else begin
                w_bit_next   = r_bit_idx - BIT_W'(1);
                w_issue      = 1'b1;
                w_mul_a      = w_r_next;
                w_mul_b      = w_r_next;
                w_next_state = S_WAIT_SQ;
            end
        end

        w_product       = WIDTH'(w_mul_a) * WIDTH'(w_mul_b);
        w_dividend_next = w_load ? WIDTH'(base) : w_product;
    end

    // Working registers, divider request, and user-visible outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp          <= '0;
            r_b_red        <= '0;
            r_r            <= '0;
            r_bit_idx      <= '0;
            r_result       <= '0;
            r_busy         <= 1'b0;
            r_finish       <= 1'b0;
            r_err          <= 1'b0;
            r_div_start    <= 1'b0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
        end else begin
            r_r         <= w_r_next;
            r_b_red     <= w_b_red_next;
            r_bit_idx   <= w_bit_next;
            r_div_start <= w_issue;
            r_finish    <= (r_state == S_DONE);
            if (w_issue) begin
                r_div_dividend <= w_dividend_next;
            end
            if (w_load) begin
                r_exp         <= exponent;
                r_div_divisor <= WIDTH'(modulus);
                r_err         <= (modulus == '0);
                r_busy        <= 1'b1;
            end
            if (r_state == S_DONE) begin
                r_result <= r_err ? '0 : r_r;
                r_busy   <= 1'b0;
            end
        end
    end

endmodule
